// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding.
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single-bit full-adder cell; the carry-out is combinational and is
// registered by the instantiating datapath.
module bit_serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic Cin,
    output logic sum,
    output logic carry
);

    logic half_s;

    assign half_s = a ^ b;
    assign sum    = half_s ^ Cin;
    assign carry  = (a & b) | (Cin & half_s);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first, with a start/busy/done handshake and registered result.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q;
    logic             done_q;

    logic             fa_sum_s;
    logic             fa_carry_s;

    bit_serial_adder_fa u_fa (
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .Cin   (carry_q),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    s_sr_d  = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_sr_d  = {fa_sum_s, s_sr_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = fa_carry_s;
                cnt_d   = cnt_q + CNT_ONE;
                // Last bit: publish the result from the freshly shifted value.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum_s, s_sr_q[WIDTH-1:1]};
                    cout_d  = fa_carry_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; reset discards any partial add.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= (state_q == RUN);
            done_q  <= (state_q == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
